// File: rtl/data_memory_responder.sv
// Data-memory slave: byte-strobed writes, 1-cycle registered reads, hardware clear after reset.
// Optional MEMORY_MISALIGN_CHECK_EN adds misaligned_error and suppresses misaligned accesses.
module data_memory_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memory_read_enable,
  input  logic [ADDR_WIDTH-1:0] memory_read_address,
  output logic [DATA_WIDTH-1:0] memory_read_data,
  output logic                  memory_read_valid,
  input  logic                  memory_write_enable,
  input  logic [ADDR_WIDTH-1:0] memory_write_address,
  input  logic [DATA_WIDTH-1:0] memory_write_data,
  input  logic [3:0]            memory_write_strobe,
  output logic                  memory_ready,
`ifdef MEMORY_MISALIGN_CHECK_EN
  output logic                  misaligned_error,
`endif
  output logic                  init_done
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int WORDS = 2 ** IDX_W;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        cnt_q, cnt_d;
  logic                    clear_en;
  logic [DATA_WIDTH-1:0]   mem_q [WORDS];
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    valid_q;
  logic                    err_q;

  logic [IDX_W-1:0]        rd_idx, wr_idx;
  logic                    rd_fire, wr_fire, wr_do;
  logic                    rd_err, wr_err;
  logic [DATA_WIDTH-1:0]   rd_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + IDX_W'(1);
      if (cnt_q == {IDX_W{1'b1}}) state_d = ST_RUN;
    end
  end

  always_comb begin
    memory_ready = (state_q == ST_RUN);
    init_done    = (state_q == ST_RUN);
    clear_en     = (state_q == ST_INIT);
  end

  assign rd_idx  = memory_read_address[ADDR_WIDTH-1:2];
  assign wr_idx  = memory_write_address[ADDR_WIDTH-1:2];
  assign rd_fire = memory_read_enable & memory_ready;
  assign wr_fire = memory_write_enable & memory_ready;

`ifdef MEMORY_MISALIGN_CHECK_EN
  assign rd_err = rd_fire & (memory_read_address[1:0] != 2'b00);
  assign wr_err = wr_fire &
                  (((memory_write_strobe == 4'b1111) && (memory_write_address[1:0] != 2'b00)) ||
                   (((memory_write_strobe == 4'b0011) || (memory_write_strobe == 4'b1100)) &&
                    memory_write_address[0]));
  assign misaligned_error = err_q;
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{memory_read_address[1:0], memory_write_address[1:0]};
  assign rd_err = 1'b0;
  assign wr_err = 1'b0;
`endif

  assign wr_do = wr_fire & ~wr_err;

  // Write-first forwarding: a same-word write in this cycle shows up in the read result.
  always_comb begin
    rd_word = mem_q[rd_idx];
    if (wr_do && (wr_idx == rd_idx)) begin
      for (int i = 0; i < 4; i++) begin
        if (memory_write_strobe[i]) rd_word[8*i +: 8] = memory_write_data[8*i +: 8];
      end
    end
    if (rd_err) rd_word = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clear_en) begin
        mem_q[cnt_q] <= '0;
      end else if (wr_do) begin
        for (int i = 0; i < 4; i++) begin
          if (memory_write_strobe[i]) mem_q[wr_idx][8*i +: 8] <= memory_write_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= rd_fire;
      if (rd_fire) rdata_q <= rd_word;
      err_q   <= rd_err | wr_err;
    end
  end

  assign memory_read_data  = rdata_q;
  assign memory_read_valid = valid_q;

endmodule
